larpix_config_responder: RTL

LARPIX_CONFIG_RESPONDER -- requirements
Module: larpix_config_responder

---
 rtl/larpix_pkg.sv | 51 +++++
 rtl/larpix_packet_check.sv | 40 ++++
 rtl/larpix_config_responder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/larpix_pkg.sv
// Shared definitions for the LArPix configuration responder: packet layout,
// constants, declare codes, check classifications and FSM states.
package larpix_pkg;

    localparam logic [31:0] MAGIC     = 32'h8950_4E47;
    localparam logic [7:0]  GLOBAL_ID = 8'hFF;

    localparam int DECL_LSB   = 0;
    localparam int CHIP_LSB   = 2;
    localparam int ADDR_LSB   = 10;
    localparam int DATA_LSB   = 18;
    localparam int MAGIC_LSB  = 26;
    localparam int MARKER_BIT = 62;
    localparam int PARITY_BIT = 63;

    typedef enum logic [1:0] {
        DECL_NONE = 2'd0,
        DATA      = 2'd1,
        CFG_WRITE = 2'd2,
        CFG_READ  = 2'd3
    } declare_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        UNLOAD    = 3'd1,
        CHECK     = 3'd2,
        WRITE     = 3'd3,
        READ      = 3'd4,
        READ_WAIT = 3'd5,
        REPLY     = 3'd6,
        SEND      = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_PARITY_ERR = 3'd0,
        CLS_IGNORE     = 3'd1,
        CLS_MAGIC_ERR  = 3'd2,
        CLS_WRITE      = 3'd3,
        CLS_READ       = 3'd4
    } pkt_class_t;

    // Odd parity: the parity bit makes the total number of ones odd.
    function automatic logic odd_parity(input logic [62:0] bits);
        return ~^bits;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

endpackage

// File: rtl/larpix_packet_check.sv
// Combinational classification of a received packet: parity, declare,
// destination ID and magic word, evaluated in that priority order.
module larpix_packet_check
    import larpix_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] pkt,
    input  logic [7:0]       chip_id,
    output pkt_class_t       pkt_class
);

    declare_t    decl_s;
    logic [7:0]  dest_s;
    logic [31:0] magic_s;
    logic        parity_ok_s;

    // Field extraction and prioritised classification.
    always_comb begin
        decl_s      = declare_t'(pkt[DECL_LSB +: 2]);
        dest_s      = pkt[CHIP_LSB +: 8];
        magic_s     = pkt[MAGIC_LSB +: 32];
        parity_ok_s = (pkt[PARITY_BIT] == odd_parity(pkt[62:0]));
        pkt_class   = CLS_IGNORE;
        if (!parity_ok_s) begin
            pkt_class = CLS_PARITY_ERR;
        end else if ((decl_s == DECL_NONE) || (decl_s == DATA)) begin
            pkt_class = CLS_IGNORE;
        end else if ((dest_s != chip_id) && (dest_s != GLOBAL_ID)) begin
            pkt_class = CLS_IGNORE;
        end else if (magic_s != MAGIC) begin
            pkt_class = CLS_MAGIC_ERR;
        end else if (decl_s == CFG_WRITE) begin
            pkt_class = CLS_WRITE;
        end else begin
            pkt_class = CLS_READ;
        end
    end

endmodule

// File: rtl/larpix_config_responder.sv
// Configuration responder: unloads packets from UART RX, performs register-map
// writes/reads, and returns a reply packet to UART TX.
module larpix_config_responder
    import larpix_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int REGNUM = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       chip_id,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_empty,
    output logic             uld_rx_data,
    output logic [7:0]       regmap_addr,
    output logic [7:0]       regmap_wdata,
    output logic             regmap_we,
    output logic             regmap_re,
    input  logic [7:0]       regmap_rdata,
    output logic [WIDTH-1:0] tx_data,
    output logic             ld_tx_data,
    input  logic             tx_busy,
    output logic [15:0]      parity_err_cnt,
    output logic [15:0]      magic_err_cnt,
    output logic [15:0]      ignored_cnt
);

    state_t           state_r, state_s;
    logic [WIDTH-1:0] pkt_r;
    logic [7:0]       reply_data_r;
    logic             uld_s, we_s, re_s, ld_s;
    logic             parity_inc_s, magic_inc_s, ignore_inc_s;
    logic             addr_oor_s;
    logic [62:0]      reply_body_s;
    pkt_class_t       pkt_class_s;

    larpix_packet_check #(.WIDTH(WIDTH)) u_check (
        .pkt       (pkt_r),
        .chip_id   (chip_id),
        .pkt_class (pkt_class_s)
    );

    // Reply body: echo declare and address, answer with our own ID and the marker set.
    always_comb begin
        addr_oor_s   = (32'(pkt_r[ADDR_LSB +: 8]) >= 32'(REGNUM));
        reply_body_s = {1'b1, 4'b0000, MAGIC, reply_data_r,
                        pkt_r[ADDR_LSB +: 8], chip_id, pkt_r[DECL_LSB +: 2]};
    end

    // Next-state and strobe decode; strobes are registered below so each one
    // is high exactly while the FSM occupies the matching state.
    always_comb begin
        state_s      = state_r;
        uld_s        = 1'b0;
        we_s         = 1'b0;
        re_s         = 1'b0;
        ld_s         = 1'b0;
        parity_inc_s = 1'b0;
        magic_inc_s  = 1'b0;
        ignore_inc_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rx_empty) begin
                    state_s = UNLOAD;
                    uld_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            UNLOAD: state_s = CHECK;
            CHECK: begin
                state_s = IDLE;
                case (pkt_class_s)
                    CLS_PARITY_ERR: parity_inc_s = 1'b1;
                    CLS_MAGIC_ERR:  magic_inc_s  = 1'b1;
                    CLS_IGNORE:     ignore_inc_s = 1'b1;
                    CLS_WRITE: begin
                        if (addr_oor_s) begin
                            ignore_inc_s = 1'b1;
                        end else begin
                            state_s = WRITE;
                            we_s    = 1'b1;
                        end
                    end
                    CLS_READ: begin
                        if (addr_oor_s) begin
                            ignore_inc_s = 1'b1;
                        end else begin
                            state_s = READ;
                            re_s    = 1'b1;
                        end
                    end
                    default: ignore_inc_s = 1'b1;
                endcase
            end
            WRITE:     state_s = REPLY;
            READ:      state_s = READ_WAIT;
            READ_WAIT: state_s = REPLY;
            REPLY: begin
                state_s = SEND;
                ld_s    = !tx_busy;
            end
            SEND: begin
                if (ld_tx_data) begin
                    state_s = IDLE;
                end else begin
                    state_s = SEND;
                    ld_s    = !tx_busy;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and registered strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            uld_rx_data <= 1'b0;
            regmap_we   <= 1'b0;
            regmap_re   <= 1'b0;
            ld_tx_data  <= 1'b0;
        end else begin
            state_r     <= state_s;
            uld_rx_data <= uld_s;
            regmap_we   <= we_s;
            regmap_re   <= re_s;
            ld_tx_data  <= ld_s;
        end
    end

    // Packet capture, register-map address/data, reply data and TX packet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_r        <= '0;
            regmap_addr  <= 8'h00;
            regmap_wdata <= 8'h00;
            reply_data_r <= 8'h00;
            tx_data      <= '0;
        end else begin
            if (state_r == UNLOAD) begin
                pkt_r <= rx_data;
            end
            if (we_s || re_s) begin
                regmap_addr  <= pkt_r[ADDR_LSB +: 8];
                regmap_wdata <= pkt_r[DATA_LSB +: 8];
                reply_data_r <= pkt_r[DATA_LSB +: 8];
            end
            if (state_r == READ_WAIT) begin
                reply_data_r <= regmap_rdata;
            end
            if (state_r == REPLY) begin
                tx_data <= WIDTH'({odd_parity(reply_body_s), reply_body_s});
            end
        end
    end

    // Saturating error and discard counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err_cnt <= 16'h0000;
            magic_err_cnt  <= 16'h0000;
            ignored_cnt    <= 16'h0000;
        end else begin
            if (parity_inc_s) parity_err_cnt <= sat_inc(parity_err_cnt);
            if (magic_inc_s)  magic_err_cnt  <= sat_inc(magic_err_cnt);
            if (ignore_inc_s) ignored_cnt    <= sat_inc(ignored_cnt);
        end
    end

endmodule
